// File: rtl/fpu_arbiter.sv
// fpu_arbiter: shares one pipelined FPU among NUM_REQ requesters.
// Round-robin grant, one-cycle registered issue, and an in-order tag FIFO
// that routes each returning result back to the requester that issued it.
module fpu_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int EXPONENT_WIDTH  = 8,
  parameter int MANTISSA_WIDTH  = 23,
  parameter int MAX_OUTSTANDING = 4,
  localparam int W     = EXPONENT_WIDTH + MANTISSA_WIDTH + 1,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*W-1:0]   req_operand_a,
  input  logic [NUM_REQ*W-1:0]   req_operand_b,
  input  logic [NUM_REQ*3-1:0]   req_operation,
  output logic                   fpu_valid_in,
  output logic [W-1:0]           fpu_operand_a,
  output logic [W-1:0]           fpu_operand_b,
  output logic [2:0]             fpu_operation,
  input  logic                   fpu_valid_out,
  input  logic [W-1:0]           fpu_result,
  input  logic                   fpu_exception,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [W-1:0]           rsp_result,
  output logic                   rsp_exception,
  output logic [CNT_W-1:0]       outstanding,
  output logic                   err_orphan
);

  localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [TAG_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   outstanding_q, outstanding_d;
  logic               fpu_valid_in_q, fpu_valid_in_d;
  logic [W-1:0]       fpu_operand_a_q, fpu_operand_a_d;
  logic [W-1:0]       fpu_operand_b_q, fpu_operand_b_d;
  logic [2:0]         fpu_operation_q, fpu_operation_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [W-1:0]       rsp_result_q, rsp_result_d;
  logic               rsp_exception_q, rsp_exception_d;
  logic               err_orphan_q, err_orphan_d;

  logic [TAG_W-1:0]   tag_mem [MAX_OUTSTANDING];
  logic [TAG_W-1:0]   tag_head;
  logic [TAG_W-1:0]   grant_idx;
  logic               grant_found;
  logic               can_accept;
  logic               accept;
  logic               pop;

  assign tag_head = tag_mem[rd_ptr_q];

  // Round-robin grant search and handshake; a response freeing a slot this
  // cycle does not open the gate until the count actually drops.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        grant_found = 1'b1;
        grant_idx   = TAG_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
    can_accept = !rst && (outstanding_q < CNT_W'(MAX_OUTSTANDING));
    accept     = can_accept && grant_found;
    req_ready  = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
    pop        = fpu_valid_out && (outstanding_q != '0);
  end

  // Next-state for issue register, tag FIFO pointers, count and responses.
  always_comb begin
    rr_ptr_d        = rr_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    outstanding_d   = outstanding_q;
    fpu_valid_in_d  = 1'b0;
    fpu_operand_a_d = fpu_operand_a_q;
    fpu_operand_b_d = fpu_operand_b_q;
    fpu_operation_d = fpu_operation_q;
    rsp_valid_d     = '0;
    rsp_result_d    = rsp_result_q;
    rsp_exception_d = rsp_exception_q;
    err_orphan_d    = err_orphan_q;

    if (accept) begin
      rr_ptr_d        = (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      wr_ptr_d        = (wr_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
      fpu_valid_in_d  = 1'b1;
      fpu_operand_a_d = req_operand_a[int'(grant_idx) * W +: W];
      fpu_operand_b_d = req_operand_b[int'(grant_idx) * W +: W];
      fpu_operation_d = req_operation[int'(grant_idx) * 3 +: 3];
    end

    if (pop) begin
      rd_ptr_d              = (rd_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
      rsp_valid_d[tag_head] = 1'b1;
      rsp_result_d          = fpu_result;
      rsp_exception_d       = fpu_exception;
    end else if (fpu_valid_out) begin
      // Result with nothing in flight: drop it and flag the protocol error.
      err_orphan_d = 1'b1;
    end

    if (accept && !pop)      outstanding_d = outstanding_q + 1'b1;
    else if (pop && !accept) outstanding_d = outstanding_q - 1'b1;
  end

  // Tag storage: written on accept, no reset needed since pointers gate reads.
  always_ff @(posedge clk) begin
    if (accept) tag_mem[wr_ptr_q] <= grant_idx;
  end

  // State registers with asynchronous clear; in-flight ops are forgotten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      outstanding_q   <= '0;
      fpu_valid_in_q  <= 1'b0;
      fpu_operand_a_q <= '0;
      fpu_operand_b_q <= '0;
      fpu_operation_q <= '0;
      rsp_valid_q     <= '0;
      rsp_result_q    <= '0;
      rsp_exception_q <= 1'b0;
      err_orphan_q    <= 1'b0;
    end else begin
      rr_ptr_q        <= rr_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      outstanding_q   <= outstanding_d;
      fpu_valid_in_q  <= fpu_valid_in_d;
      fpu_operand_a_q <= fpu_operand_a_d;
      fpu_operand_b_q <= fpu_operand_b_d;
      fpu_operation_q <= fpu_operation_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_result_q    <= rsp_result_d;
      rsp_exception_q <= rsp_exception_d;
      err_orphan_q    <= err_orphan_d;
    end
  end

  assign fpu_valid_in  = fpu_valid_in_q;
  assign fpu_operand_a = fpu_operand_a_q;
  assign fpu_operand_b = fpu_operand_b_q;
  assign fpu_operation = fpu_operation_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_result    = rsp_result_q;
  assign rsp_exception = rsp_exception_q;
  assign outstanding   = outstanding_q;
  assign err_orphan    = err_orphan_q;

endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed bench for fpu_arbiter with 4 requesters, 32-bit operands and
// up to 4 outstanding ops; the bench itself plays the FPU.
module tb_fpu_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_operand_a;
  logic [N*W-1:0] req_operand_b;
  logic [N*3-1:0] req_operation;
  logic           fpu_valid_in;
  logic [W-1:0]   fpu_operand_a;
  logic [W-1:0]   fpu_operand_b;
  logic [2:0]     fpu_operation;
  logic           fpu_valid_out;
  logic [W-1:0]   fpu_result;
  logic           fpu_exception;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_result;
  logic           rsp_exception;
  logic [2:0]     outstanding;
  logic           err_orphan;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] opa [N];
  logic [W-1:0] opb [N];
  logic [2:0]   opc [N];

  fpu_arbiter #(.NUM_REQ(N), .EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_operand_a(req_operand_a), .req_operand_b(req_operand_b), .req_operation(req_operation),
    .fpu_valid_in(fpu_valid_in), .fpu_operand_a(fpu_operand_a), .fpu_operand_b(fpu_operand_b),
    .fpu_operation(fpu_operation),
    .fpu_valid_out(fpu_valid_out), .fpu_result(fpu_result), .fpu_exception(fpu_exception),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_exception(rsp_exception),
    .outstanding(outstanding), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    fpu_valid_out = 1'b0;
    fpu_result = '0;
    fpu_exception = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 4'b1111;
    fpu_valid_out = 1'b0;
    fpu_result = '0;
    fpu_exception = 1'b0;
    tick();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    checks++; if (fpu_valid_in !== 1'b0) begin errors++; $display("FAIL reset_fpu_valid_in got %b exp 0", fpu_valid_in); end
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0000", rsp_valid); end
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL reset_outstanding got %0d exp 0", outstanding); end
    checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL reset_err_orphan got %b exp 0", err_orphan); end
    checks++; if (fpu_operand_a !== 32'h0 || rsp_result !== 32'h0) begin errors++; $display("FAIL reset_data got a=%h rsp=%h exp 0", fpu_operand_a, rsp_result); end
    req_valid = '0;
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b exp 0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    checks++; if (fpu_valid_in !== 1'b1) begin errors++; $display("FAIL single_issue got %b exp 1", fpu_valid_in); end
    checks++; if (fpu_operand_a !== 32'h3F800000 || fpu_operand_b !== 32'h3F800000 || fpu_operation !== 3'b000)
      begin errors++; $display("FAIL single_operands got a=%h b=%h op=%b exp 3f800000 3f800000 000", fpu_operand_a, fpu_operand_b, fpu_operation); end
    checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL single_outstanding got %0d exp 1", outstanding); end
    tick();
    checks++; if (fpu_valid_in !== 1'b0) begin errors++; $display("FAIL single_pulse got %b exp 0", fpu_valid_in); end
    checks++; if (fpu_operand_a !== 32'h3F800000) begin errors++; $display("FAIL single_hold got %h exp 3f800000", fpu_operand_a); end
    fpu_valid_out = 1'b1;
    fpu_result = 32'h40000000;
    fpu_exception = 1'b1;
    tick();
    fpu_valid_out = 1'b0;
    fpu_exception = 1'b0;
    checks++; if (rsp_valid !== 4'b0001 || rsp_result !== 32'h40000000 || rsp_exception !== 1'b1)
      begin errors++; $display("FAIL single_rsp got v=%b r=%h e=%b exp 0001 40000000 1", rsp_valid, rsp_result, rsp_exception); end
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL single_drain got %0d exp 0", outstanding); end
    tick();
    checks++; if (rsp_valid !== 4'b0000 || rsp_result !== 32'h40000000 || rsp_exception !== 1'b1)
      begin errors++; $display("FAIL single_rsp_hold got v=%b r=%h e=%b exp 0000 40000000 1", rsp_valid, rsp_result, rsp_exception); end
    $display("test_single done");
  endtask

  task automatic test_fairness();
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      req_valid = 4'b1111;
      fpu_valid_out = (k > 0);
      fpu_result = 32'hA0000000 + (k - 1);
      #1;
      checks++; if (req_ready !== 4'(1 << exp_seq[k])) begin errors++; $display("FAIL fair_ready[%0d] got %b exp %b", k, req_ready, 4'(1 << exp_seq[k])); end
      tick();
      checks++; if (fpu_valid_in !== 1'b1 || fpu_operand_a !== opa[exp_seq[k]])
        begin errors++; $display("FAIL fair_issue[%0d] got v=%b a=%h exp 1 %h", k, fpu_valid_in, fpu_operand_a, opa[exp_seq[k]]); end
      if (k > 0) begin
        checks++; if (rsp_valid !== 4'(1 << exp_seq[k-1]) || rsp_result !== 32'hA0000000 + (k - 1))
          begin errors++; $display("FAIL fair_rsp[%0d] got v=%b r=%h exp %b %h", k, rsp_valid, rsp_result, 4'(1 << exp_seq[k-1]), 32'hA0000000 + (k - 1)); end
      end
    end
    req_valid = '0;
    fpu_valid_out = 1'b1;
    fpu_result = 32'hA0000004;
    tick();
    fpu_valid_out = 1'b0;
    checks++; if (rsp_valid !== 4'b0001 || rsp_result !== 32'hA0000004)
      begin errors++; $display("FAIL fair_rsp_last got v=%b r=%h exp 0001 a0000004", rsp_valid, rsp_result); end
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL fair_drain got %0d exp 0", outstanding); end
    $display("test_fairness done");
  endtask

  task automatic test_full();
    do_reset();
    req_valid = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL full_ready[%0d] got %b exp 0001", k, req_ready); end
      tick();
    end
    #1;
    checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", outstanding); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL full_blocked got %b exp 0000", req_ready); end
    fpu_valid_out = 1'b1;
    fpu_result = 32'hBEEF0001;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL full_same_cycle got %b exp 0000", req_ready); end
    tick();
    fpu_valid_out = 1'b0;
    checks++; if (outstanding !== 3'd3 || rsp_valid !== 4'b0001 || fpu_valid_in !== 1'b0)
      begin errors++; $display("FAIL full_free got cnt=%0d v=%b iss=%b exp 3 0001 0", outstanding, rsp_valid, fpu_valid_in); end
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL full_ready_back got %b exp 0001", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (outstanding !== 3'd4 || fpu_valid_in !== 1'b1)
      begin errors++; $display("FAIL full_refill got cnt=%0d iss=%b exp 4 1", outstanding, fpu_valid_in); end
    fpu_valid_out = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL full_drain[%0d] got %b exp 0001", k, rsp_valid); end
    end
    fpu_valid_out = 1'b0;
    checks++; if (outstanding !== 3'd0 || err_orphan !== 1'b0)
      begin errors++; $display("FAIL full_empty got cnt=%0d orphan=%b exp 0 0", outstanding, err_orphan); end
    $display("test_full done");
  endtask

  task automatic test_simultaneous();
    do_reset();
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0100;
    tick();
    checks++; if (outstanding !== 3'd2) begin errors++; $display("FAIL simul_pre got %0d exp 2", outstanding); end
    req_valid = 4'b1000;
    fpu_valid_out = 1'b1;
    fpu_result = 32'h00000055;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL simul_ready got %b exp 1000", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (outstanding !== 3'd2) begin errors++; $display("FAIL simul_count got %0d exp 2", outstanding); end
    checks++; if (rsp_valid !== 4'b0010 || rsp_result !== 32'h00000055)
      begin errors++; $display("FAIL simul_tag got v=%b r=%h exp 0010 00000055", rsp_valid, rsp_result); end
    checks++; if (fpu_valid_in !== 1'b1 || fpu_operand_b !== opb[3] || fpu_operation !== opc[3])
      begin errors++; $display("FAIL simul_issue got v=%b b=%h op=%b exp 1 %h %b", fpu_valid_in, fpu_operand_b, fpu_operation, opb[3], opc[3]); end
    tick();
    checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL simul_tag2 got %b exp 0100", rsp_valid); end
    tick();
    fpu_valid_out = 1'b0;
    checks++; if (rsp_valid !== 4'b1000 || outstanding !== 3'd0)
      begin errors++; $display("FAIL simul_tag3 got v=%b cnt=%0d exp 1000 0", rsp_valid, outstanding); end
    $display("test_simultaneous done");
  endtask

  task automatic test_orphan();
    do_reset();
    fpu_valid_out = 1'b1;
    fpu_result = 32'h12345678;
    tick();
    fpu_valid_out = 1'b0;
    checks++; if (err_orphan !== 1'b1 || rsp_valid !== 4'b0000 || outstanding !== 3'd0)
      begin errors++; $display("FAIL orphan_set got e=%b v=%b cnt=%0d exp 1 0000 0", err_orphan, rsp_valid, outstanding); end
    checks++; if (rsp_result !== 32'h0) begin errors++; $display("FAIL orphan_drop got %h exp 0", rsp_result); end
    tick();
    tick();
    checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_sticky got %b exp 1", err_orphan); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL orphan_clear got %b exp 0", err_orphan); end
    rst = 1'b0;
    $display("test_orphan done");
  endtask

  task automatic test_reset_midop();
    do_reset();
    req_valid = 4'b0001;
    for (int k = 0; k < 4; k++) tick();
    req_valid = 4'b0000;
    fpu_valid_out = 1'b1;
    fpu_result = 32'hDEADBEEF;
    tick();
    fpu_valid_out = 1'b0;
    checks++; if (outstanding !== 3'd3 || rsp_valid !== 4'b0001 || rsp_result !== 32'hDEADBEEF)
      begin errors++; $display("FAIL midop_pre got cnt=%0d v=%b r=%h exp 3 0001 deadbeef", outstanding, rsp_valid, rsp_result); end
    #2;
    req_valid = 4'b0001;
    rst = 1'b1;
    #1;
    checks++; if (outstanding !== 3'd0 || rsp_valid !== 4'b0000 || rsp_result !== 32'h0 || req_ready !== 4'b0000)
      begin errors++; $display("FAIL midop_clear got cnt=%0d v=%b r=%h rdy=%b exp 0 0000 0 0000", outstanding, rsp_valid, rsp_result, req_ready); end
    checks++; if (fpu_operand_a !== 32'h0 || fpu_operation !== 3'b000 || fpu_valid_in !== 1'b0)
      begin errors++; $display("FAIL midop_fpu_clear got a=%h op=%b v=%b exp 0 000 0", fpu_operand_a, fpu_operation, fpu_valid_in); end
    rst = 1'b0;
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL midop_ready got %b exp 0100", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (fpu_valid_in !== 1'b1 || fpu_operand_a !== opa[2] || outstanding !== 3'd1)
      begin errors++; $display("FAIL midop_issue got v=%b a=%h cnt=%0d exp 1 %h 1", fpu_valid_in, fpu_operand_a, outstanding, opa[2]); end
    fpu_valid_out = 1'b1;
    fpu_result = 32'h12345678;
    tick();
    checks++; if (rsp_valid !== 4'b0100 || rsp_result !== 32'h12345678 || err_orphan !== 1'b0)
      begin errors++; $display("FAIL midop_rsp got v=%b r=%h e=%b exp 0100 12345678 0", rsp_valid, rsp_result, err_orphan); end
    tick();
    fpu_valid_out = 1'b0;
    checks++; if (err_orphan !== 1'b1 || rsp_valid !== 4'b0000)
      begin errors++; $display("FAIL midop_late got e=%b v=%b exp 1 0000", err_orphan, rsp_valid); end
    $display("test_reset_midop done");
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      opa[i] = 32'h3F800000 + 32'(i) * 32'h100;
      opb[i] = 32'h3F800000 + 32'(i) * 32'h10;
      opc[i] = 3'(i);
      req_operand_a[i*W +: W] = opa[i];
      req_operand_b[i*W +: W] = opb[i];
      req_operation[i*3 +: 3] = opc[i];
    end
    test_reset();
    test_single();
    test_fairness();
    test_full();
    test_simultaneous();
    test_orphan();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
